// File: rtl/ksa_share_arb_pkg.sv
// ksa_share_arb_pkg: shared state encoding, tag type and adder latency for ksa_share_arb.
// The tag index is sized for the largest supported requester count (16).
package ksa_share_arb_pkg;
    localparam int ADDER_LAT = 3;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;
endpackage

// File: rtl/ksa_share_rr_pick.sv
// ksa_share_rr_pick: combinational round-robin picker, one-hot grant on the first valid
// requester at or after the pointer.
module ksa_share_rr_pick
    import ksa_share_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] index
);
    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req_valid[j]) begin
                grant[j] = 1'b1;
                index    = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ksa_share_arb.sv
// ksa_share_arb: round-robin sharing of one pipelined Kogge-Stone adder among NREQ requesters.
// Define KSA_SHARE_ARB_CHECK_EN to carry a golden sum with each tag and flag adder errors on err.
module ksa_share_arb
    import ksa_share_arb_pkg::*;
#(
    parameter int BITS   = 64,
    parameter int LEVELS = 6,
    parameter int NREQ   = 4,
    parameter int LAT    = ADDER_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    input  logic [NREQ-1:0]      req_c,
    output logic [NREQ-1:0]      req_ready,
    output logic [BITS-1:0]      add_a,
    output logic [BITS-1:0]      add_b,
    output logic                 add_c,
    input  logic [BITS:0]        add_s,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [BITS:0]        rsp_sum,
    output logic                 idle,
    output logic                 err
);
    if (LAT != ADDER_LAT || LEVELS != $clog2(BITS + 1) - 1 || NREQ < 2 || NREQ > 16) begin : g_bad_cfg
        $error("ksa_share_arb: unsupported parameter combination");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx;
    logic [NREQ-1:0]  grant;
    logic             xfer, add_c_q, add_c_d, pipe_empty_d, pipe_empty_q;
    tag_t             pipe_q [LAT];
    tag_t             pipe_d [LAT];

    ksa_share_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .index     (idx)
    );

    always_comb begin
        req_ready = state_q == ST_RUN ? grant : '0;
        xfer      = |req_ready;
        add_a     = '0;
        add_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            add_a |= req_ready[i] ? req_a[i*BITS +: BITS] : '0;
            add_b |= req_ready[i] ? req_b[i*BITS +: BITS] : '0;
        end
        add_c_d = |(req_c & req_ready);
        ptr_d   = !xfer ? ptr_q : (int'(idx) == NREQ - 1) ? '0 : idx + IDX_W'(1);
        pipe_d[0] = '{valid: xfer, index: idx};
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
        pipe_empty_d = 1'b1;
        pipe_empty_q = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            pipe_empty_d &= !pipe_d[i].valid;
            pipe_empty_q &= !pipe_q[i].valid;
        end
        // DRAIN leaves as soon as nothing will remain in flight after this edge
        state_d = en ? ST_RUN
                : state_q == ST_RUN ? ST_DRAIN
                : (state_q == ST_IDLE || pipe_empty_d) ? ST_IDLE : ST_DRAIN;
        rsp_valid = pipe_q[LAT-1].valid ? NREQ'(1) << pipe_q[LAT-1].index : '0;
        rsp_sum   = pipe_q[LAT-1].valid ? add_s : '0;
        idle      = state_q == ST_IDLE && pipe_empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            add_c_q <= 1'b0;
            pipe_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            add_c_q <= add_c_d;
            pipe_q  <= pipe_d;
        end
    end

    assign add_c = add_c_q;

`ifdef KSA_SHARE_ARB_CHECK_EN
    logic [BITS:0] gold_q [LAT];
    logic [BITS:0] gold_d [LAT];
    logic          err_q, err_d, bad;

    always_comb begin
        gold_d[0] = {1'b0, add_a} + {1'b0, add_b} + {{BITS{1'b0}}, add_c_d};
        for (int i = 1; i < LAT; i++) gold_d[i] = gold_q[i-1];
        bad   = pipe_q[LAT-1].valid && gold_q[LAT-1] != add_s;
        err_d = err_q | bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gold_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            gold_q <= gold_d;
            err_q  <= err_d;
`ifndef SYNTHESIS
            if (bad)
                $display("%0t ksa_share_arb: sum check error idx %0d adder %h expected %h",
                         $time, pipe_q[LAT-1].index, add_s, gold_q[LAT-1]);
`endif
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ksa_share_arb.sv
// tb_ksa_share_arb: randomized scoreboard bench for ksa_share_arb with a behavioural adder model.
module tb_ksa_share_arb;
    localparam int BITS = 64;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    typedef struct {
        int            idx;
        logic [BITS:0] sum;
        int            due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*BITS-1:0] req_a = '0;
    logic [NREQ*BITS-1:0] req_b = '0;
    logic [NREQ-1:0]      req_c = '0;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [BITS-1:0]      add_a, add_b;
    logic                 add_c, idle, err;
    logic [BITS:0]        add_s, rsp_sum;

    ksa_share_arb #(.BITS(BITS), .LEVELS(6), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_c(req_c), .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .add_s(add_s), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder: operands captured at the grant edge, carry one stage later, sum valid LAT cycles on
    logic [BITS-1:0] s1a = '0, s1b = '0;
    logic [BITS:0]   s2 = '0, s3 = '0;
    logic            inj = 1'b0;
    always @(posedge clk) begin
        s1a <= add_a;
        s1b <= add_b;
        s2  <= {1'b0, s1a} + {1'b0, s1b} + {{BITS{1'b0}}, add_c};
        s3  <= s2;
    end
    assign add_s = s3 ^ {{BITS{1'b0}}, inj};

    int   n_vec = 0, n_err = 0;
    exp_t q[$];
    exp_t e;
    bit   err_m = 1'b0;

    task automatic chk(input string nm, input logic [BITS:0] act, input logic [BITS:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a response is presented
    always @(negedge clk) if (rst_n) begin
        if (rsp_valid != '0) begin
            if (q.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
            else begin
                e = q.pop_front();
                chk("rsp_valid", rsp_valid, (BITS+1)'(1) << e.idx);
                chk("rsp_sum", rsp_sum, e.sum ^ {{BITS{1'b0}}, inj});
                chk("rsp_cycle", cyc, e.due);
            end
        end else begin
            chk("rsp_sum_zero", rsp_sum, '0);
            if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 1, 0);
                void'(q.pop_front());
            end
        end
        chk("err", err, err_m);
`ifdef KSA_SHARE_ARB_CHECK_EN
        if (inj && rsp_valid != '0) err_m = 1'b1;
`endif
    end

    logic [NREQ-1:0] v_in = '0;
    bit              en_in = 1'b0, inj_in = 1'b0;
    logic [BITS-1:0] a_in [NREQ];
    logic [BITS-1:0] b_in [NREQ];
    bit              c_in [NREQ];
    bit              m_run = 1'b0, m_c = 1'b0;
    int              m_ptr = 0, last_due = 0;

    // One clock: apply inputs, predict the grant from the round-robin rule, check at negedge
    task automatic step();
        int g;
        exp_t x;
        @(posedge clk);
        #1;
        en = en_in;
        inj = inj_in;
        req_valid = v_in;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BITS +: BITS] = a_in[i];
            req_b[i*BITS +: BITS] = b_in[i];
            req_c[i] = c_in[i];
        end
        g = -1;
        if (m_run)
            for (int i = 0; i < NREQ; i++)
                if (g < 0 && v_in[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        @(negedge clk);
        chk("add_c", add_c, m_c);
        if (g < 0) begin
            chk("req_ready", req_ready, '0);
            chk("add_a_zero", add_a, '0);
            chk("add_b_zero", add_b, '0);
            m_c = 1'b0;
        end else begin
            chk("req_ready", req_ready, (BITS+1)'(1) << g);
            chk("add_a", add_a, a_in[g]);
            chk("add_b", add_b, b_in[g]);
            x.idx = g;
            x.sum = {1'b0, a_in[g]} + {1'b0, b_in[g]} + {{BITS{1'b0}}, c_in[g]};
            x.due = cyc + LAT;
            q.push_back(x);
            last_due = x.due;
            m_c = c_in[g];
            m_ptr = (g + 1) % NREQ;
        end
        m_run = en_in;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        en = 1'b0;
        req_valid = '0;
        en_in = 1'b0;
        v_in = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_sum", rsp_sum, '0);
        chk("rst_err", err, '0);
        chk("rst_idle", idle, 1);
        chk("rst_add_c", add_c, '0);
        q.delete();
        m_run = 1'b0;
        m_c = 1'b0;
        m_ptr = 0;
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b, input bit c);
        a_in[i] = a;
        b_in[i] = b;
        c_in[i] = c;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("reset_idle", idle, 1);
        chk("reset_ready", req_ready, '0);

        en_in = 1'b1;
        step();
        set_op(0, 64'd5, 64'd7, 1'b1);
        v_in = 4'b0001;
        step();
        v_in = '0;
        repeat (4) step();

        for (int i = 0; i < NREQ; i++) set_op(i, 64'h1000 * (i + 1), 64'h11 * (i + 3), i[0]);
        v_in = 4'hf;
        repeat (6) step();

        v_in = '0;
        step();
        set_op(0, '1, '1, 1'b1);
        set_op(1, 64'd1, 64'd2, 1'b0);
        set_op(2, '1, 64'd0, 1'b0);
        set_op(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        v_in = 4'hf;
        repeat (4) step();
        v_in = '0;
        repeat (4) step();

        step();
        v_in = 4'b0011;
        step();
        en_in = 1'b0;
        step();
        v_in = 4'hf;
        repeat (5) begin
            step();
            chk("drain_idle", idle, cyc > last_due);
        end
        en_in = 1'b1;
        repeat (4) step();
        v_in = '0;
        repeat (4) step();

        v_in = 4'b0001;
        set_op(0, 64'd100, 64'd23, 1'b0);
        step();
        v_in = '0;
        repeat (2) step();
        inj_in = 1'b1;
        step();
        inj_in = 1'b0;
        repeat (3) step();

        repeat (300) begin
            en_in = $urandom_range(0, 7) != 0;
            v_in = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 9) == 0) set_op(i, '1, '1, 1'($urandom));
                else set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            step();
        end

        en_in = 1'b1;
        v_in = '0;
        step();
        v_in = 4'hf;
        repeat (3) step();
        do_reset();
        en_in = 1'b1;
        repeat (3) step();
        v_in = '0;
        repeat (5) step();

        en_in = 1'b0;
        repeat (LAT + 2) step();
        chk("queue_empty", q.size(), 0);
        chk("final_idle", idle, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
